// File: rtl/aes_stream_cipher_if.sv
// Valid/ready stream bundle for aes_stream_cipher: input beats towards the
// cipher and result beats back to the sink.
interface aes_stream_cipher_if #(
    parameter int DATA_BYTES = 1
);
    logic                    valid_in;
    logic                    ready_in;
    logic [8*DATA_BYTES-1:0] data_in;
    logic                    valid_out;
    logic                    ready_out;
    logic [8*DATA_BYTES-1:0] data_out;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out
    );
endinterface

// File: rtl/aes_stream_cipher.sv
// Byte-oriented keyed XOR/rotate stream cipher with a two-stage stallable
// pipeline; key and mode are captured per message by new_message.
module aes_stream_cipher #(
    parameter int DATA_BYTES = 1,
    parameter int KEY_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_message,
    input  logic                   mode,
    input  logic [8*KEY_BYTES-1:0] key,
    aes_stream_cipher_if.slave     bus
);
    localparam int         DW           = 8 * DATA_BYTES;
    localparam int         KW           = 8 * KEY_BYTES;
    localparam logic [7:0] KEY_BYTES_B  = 8'(KEY_BYTES);
    localparam logic [7:0] DATA_BYTES_B = 8'(DATA_BYTES);

    logic [KW-1:0] key_r;
    logic          mode_r;
    logic [7:0]    idx_r;

    logic          s1_valid_r;
    logic [DW-1:0] s1_data_r;
    logic [DW-1:0] s1_ks_r;
    logic          s1_mode_r;
    logic          s2_valid_r;
    logic [DW-1:0] s2_data_r;

    logic          en_s;
    logic          accept_s;
    logic [KW-1:0] key_eff_s;
    logic          mode_eff_s;
    logic [7:0]    idx_base_s;
    logic [DW-1:0] ks_s;
    logic [DW-1:0] result_s;

    function automatic logic [7:0] key_byte(input logic [KW-1:0] k, input logic [7:0] sel);
        logic [7:0] b;
        b = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            b = (sel == 8'(n)) ? k[8*n +: 8] : b;
        end
        return b;
    endfunction

    function automatic logic [7:0] ks_byte(input logic [KW-1:0] k, input logic [7:0] i);
        return key_byte(k, i % KEY_BYTES_B) + i;
    endfunction

    function automatic logic [7:0] crypt_byte(input logic [7:0] d, input logic [7:0] ks, input logic m);
        logic [7:0] x;
        logic [7:0] y;
        if (m == 1'b0) begin
            x = d ^ ks;
            y = {x[4:0], x[7:5]};
        end else begin
            x = {d[2:0], d[7:3]};
            y = x ^ ks;
        end
        return y;
    endfunction

    // Handshake, effective message context and per-lane keystream/result.
    always_comb begin
        en_s       = !s2_valid_r || bus.ready_out;
        accept_s   = bus.valid_in && en_s;
        // A beat arriving with new_message already belongs to the new message.
        key_eff_s  = new_message ? key  : key_r;
        mode_eff_s = new_message ? mode : mode_r;
        idx_base_s = new_message ? 8'h00 : idx_r;
        ks_s       = {DW{1'b0}};
        result_s   = {DW{1'b0}};
        for (int j = 0; j < DATA_BYTES; j++) begin
            ks_s[8*j +: 8]     = ks_byte(key_eff_s, idx_base_s + 8'(j));
            result_s[8*j +: 8] = crypt_byte(s1_data_r[8*j +: 8], s1_ks_r[8*j +: 8], s1_mode_r);
        end
    end

    // Message context: key, mode and stream byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_r  <= {KW{1'b0}};
            mode_r <= 1'b0;
            idx_r  <= 8'h00;
        end else if (new_message) begin
            key_r  <= key;
            mode_r <= mode;
            idx_r  <= accept_s ? DATA_BYTES_B : 8'h00;
        end else if (accept_s) begin
            idx_r  <= idx_r + DATA_BYTES_B;
        end else begin
            idx_r  <= idx_r;
        end
    end

    // Two pipeline stages, both frozen while the sink holds off a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DW{1'b0}};
            s1_ks_r    <= {DW{1'b0}};
            s1_mode_r  <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_data_r  <= {DW{1'b0}};
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r <= bus.data_in;
                s1_ks_r   <= ks_s;
                s1_mode_r <= mode_eff_s;
            end else begin
                s1_data_r <= s1_data_r;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= result_s;
            end else begin
                s2_data_r <= s2_data_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign bus.ready_in  = en_s;
    assign bus.valid_out = s2_valid_r;
    assign bus.data_out  = s2_data_r;
endmodule

// File: tb/tb_aes_stream_cipher.sv
// Randomised and directed bench for aes_stream_cipher (1-byte and 4-byte
// lanes) against a queue-based reference of the keystream rules.
module tb_aes_stream_cipher;
    logic        clk = 1'b0;
    logic        reset;
    logic        nm;
    logic        mode;
    logic [31:0] key;

    aes_stream_cipher_if #(.DATA_BYTES(1)) bus_n ();
    aes_stream_cipher_if #(.DATA_BYTES(4)) bus_w ();

    aes_stream_cipher #(.DATA_BYTES(1), .KEY_BYTES(4)) dut_n (
        .clk(clk), .reset(reset), .new_message(nm), .mode(mode), .key(key), .bus(bus_n)
    );
    aes_stream_cipher #(.DATA_BYTES(4), .KEY_BYTES(4)) dut_w (
        .clk(clk), .reset(reset), .new_message(nm), .mode(mode), .key(key), .bus(bus_w)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: nb lanes starting at stream position idx.
    function automatic logic [31:0] ref_beat(input logic [31:0] din, input int nb,
                                             input logic [31:0] k, input logic m, input int idx);
        logic [31:0] r;
        r = 32'd0;
        for (int j = 0; j < nb; j++) begin
            int i;
            int ks;
            int x;
            int y;
            i  = (idx + j) % 256;
            ks = ((int'((k >> (8 * (i % 4))) & 32'hFF)) + i) % 256;
            x  = int'((din >> (8 * j)) & 32'hFF);
            if (m == 1'b0) begin
                x = x ^ ks;
                y = ((x * 8) | (x / 32)) % 256;
            end else begin
                y = (((x / 8) | (x * 32)) % 256) ^ ks;
            end
            r = r | (32'(y) << (8 * j));
        end
        return r;
    endfunction

    logic [31:0] mk;
    logic        mm;
    int          mi_n, mi_w;
    logic [31:0] exp_n[$], exp_w[$], got_n[$], got_w[$];
    logic        stall_n, stall_w;
    logic [31:0] held_n, held_w;

    // Monitor: values seen at negedge are what the next rising edge acts on.
    always @(negedge clk) begin
        if (reset) begin
            mk = 32'd0; mm = 1'b0; mi_n = 0; mi_w = 0;
            exp_n.delete(); exp_w.delete();
            stall_n = 1'b0; stall_w = 1'b0;
        end else begin
            if (stall_n) begin
                check_val("hold_vld_n", 32'(bus_n.valid_out), 32'd1);
                check_val("hold_dat_n", 32'(bus_n.data_out), held_n);
            end
            if (stall_w) begin
                check_val("hold_vld_w", 32'(bus_w.valid_out), 32'd1);
                check_val("hold_dat_w", bus_w.data_out, held_w);
            end
            check_val("rdy_in_n", 32'(bus_n.ready_in), 32'(!bus_n.valid_out || bus_n.ready_out));
            check_val("rdy_in_w", 32'(bus_w.ready_in), 32'(!bus_w.valid_out || bus_w.ready_out));
            if (bus_n.valid_out && bus_n.ready_out) begin
                got_n.push_back(32'(bus_n.data_out));
                if (exp_n.size() == 0) check_val("spurious_n", 32'(bus_n.data_out), 32'hDEAD_BEEF);
                else check_val("data_n", 32'(bus_n.data_out), exp_n.pop_front());
            end
            if (bus_w.valid_out && bus_w.ready_out) begin
                got_w.push_back(bus_w.data_out);
                if (exp_w.size() == 0) check_val("spurious_w", bus_w.data_out, 32'hDEAD_BEEF);
                else check_val("data_w", bus_w.data_out, exp_w.pop_front());
            end
            if (nm) begin
                mk = key; mm = mode; mi_n = 0; mi_w = 0;
            end
            if (bus_n.valid_in && bus_n.ready_in) begin
                exp_n.push_back(ref_beat(32'(bus_n.data_in), 1, mk, mm, mi_n));
                mi_n = (mi_n + 1) % 256;
            end
            if (bus_w.valid_in && bus_w.ready_in) begin
                exp_w.push_back(ref_beat(bus_w.data_in, 4, mk, mm, mi_w));
                mi_w = (mi_w + 4) % 256;
            end
            stall_n = bus_n.valid_out && !bus_n.ready_out;
            held_n  = 32'(bus_n.data_out);
            stall_w = bus_w.valid_out && !bus_w.ready_out;
            held_w  = bus_w.data_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        nm = 1'b0;
    endtask

    task automatic send(input bit wide, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        if (wide) begin
            bus_w.valid_in = 1'b1; bus_w.data_in = d;
        end else begin
            bus_n.valid_in = 1'b1; bus_n.data_in = d[7:0];
        end
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = wide ? bus_w.ready_in : bus_n.ready_in;
            tick();
        end
        check_val("send_acc", 32'(acc), 32'd1);
        bus_w.valid_in = 1'b0;
        bus_n.valid_in = 1'b0;
    endtask

    task automatic new_msg(input logic [31:0] k, input logic m);
        key = k; mode = m; nm = 1'b1;
        tick();
    endtask

    task automatic drain();
        bus_n.ready_out = 1'b1;
        bus_w.ready_out = 1'b1;
        for (int n = 0; n < 50 && (exp_n.size() != 0 || exp_w.size() != 0); n++) tick();
        tick(); tick();
        check_val("drain_n", 32'(exp_n.size()), 32'd0);
        check_val("drain_w", 32'(exp_w.size()), 32'd0);
    endtask

    task automatic check_seq(input string tag, input int at, input logic [31:0] exp);
        check_val(tag, (got_n.size() > at) ? got_n[at] : 32'hFFFF_FFFF, exp);
    endtask

    logic [7:0] enc_zero[12] = '{8'h08, 8'h18, 8'h28, 8'h38, 8'h28, 8'h38,
                                 8'h48, 8'h58, 8'h48, 8'h58, 8'h68, 8'h78};
    bit done;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; nm = 1'b0; mode = 1'b0; key = 32'd0;
        bus_n.valid_in = 1'b0; bus_n.data_in = 8'h00; bus_n.ready_out = 1'b1;
        bus_w.valid_in = 1'b0; bus_w.data_in = 32'd0; bus_w.ready_out = 1'b1;
        #12;
        check_val("rst_vout_n", 32'(bus_n.valid_out), 32'd0);
        check_val("rst_dout_n", 32'(bus_n.data_out), 32'd0);
        check_val("rst_rin_n", 32'(bus_n.ready_in), 32'd1);
        check_val("rst_vout_w", 32'(bus_w.valid_out), 32'd0);
        check_val("rst_dout_w", bus_w.data_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Encrypt sequence and latency
        new_msg(32'h04030201, 1'b0);
        got_n.delete();
        send(1'b0, 32'h00);
        check_val("lat_v1", 32'(bus_n.valid_out), 32'd0);
        send(1'b0, 32'h00);
        check_val("lat_v2", 32'(bus_n.valid_out), 32'd1);
        check_val("lat_d2", 32'(bus_n.data_out), 32'h08);
        repeat (3) send(1'b0, 32'h00);
        drain();
        for (int i = 0; i < 5; i++) check_seq("enc_seq", i, 32'(enc_zero[i]));

        // Decrypt
        new_msg(32'h04030201, 1'b1);
        got_n.delete();
        send(1'b0, 32'h08);
        send(1'b0, 32'h18);
        drain();
        check_seq("dec_0", 0, 32'h00);
        check_seq("dec_1", 1, 32'h00);

        // Backpressure for 3 cycles mid-stream
        new_msg(32'h04030201, 1'b0);
        got_n.delete();
        fork
            repeat (12) send(1'b0, 32'h00);
            begin
                repeat (4) begin @(posedge clk); #1; end
                bus_n.ready_out = 1'b0;
                #1;
                check_val("bp_rin", 32'(bus_n.ready_in), 32'd0);
                check_val("bp_vout", 32'(bus_n.valid_out), 32'd1);
                repeat (3) begin @(posedge clk); #1; end
                bus_n.ready_out = 1'b1;
            end
        join
        drain();
        check_val("bp_count", 32'(got_n.size()), 32'd12);
        for (int i = 0; i < 12; i++) check_seq("bp_seq", i, 32'(enc_zero[i]));

        // Index wrap-around
        new_msg(32'h04030201, 1'b0);
        got_n.delete();
        repeat (257) send(1'b0, 32'h00);
        drain();
        check_seq("wrap_0", 0, 32'h08);
        check_seq("wrap_256", 256, 32'h08);

        // Restart while old beats are in flight
        new_msg(32'h04030201, 1'b0);
        got_n.delete();
        send(1'b0, 32'h11);
        send(1'b0, 32'h22);
        key = 32'hFFFF_FFFF; mode = 1'b0; nm = 1'b1;
        send(1'b0, 32'h00);
        drain();
        check_seq("rst_old0", 0, 32'h80);
        check_seq("rst_old1", 1, 32'h09);
        check_seq("rst_new", 2, 32'hFF);

        // Wide lanes
        new_msg(32'h04030201, 1'b0);
        got_w.delete();
        send(1'b1, 32'h0000_0000);
        drain();
        check_val("wide_beat", (got_w.size() > 0) ? got_w[0] : 32'hFFFF_FFFF, 32'h3828_1808);

        // Randomised traffic with random backpressure and restarts
        done = 1'b0;
        fork
            begin
                for (int r = 0; r < 300; r++) begin
                    case ($urandom_range(0, 5))
                        0, 1: send(1'b0, 32'($urandom_range(0, 255)));
                        2: send(1'b1, $urandom);
                        3: begin
                            key = $urandom; mode = 1'($urandom_range(0, 1)); nm = 1'b1;
                            send(1'b0, 32'($urandom_range(0, 255)));
                        end
                        4: new_msg($urandom, 1'($urandom_range(0, 1)));
                        default: tick();
                    endcase
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus_n.ready_out = 1'($urandom_range(0, 1));
                    bus_w.ready_out = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        // Reset mid-stream discards in-flight beats
        new_msg(32'h04030201, 1'b0);
        send(1'b1, 32'h1234_5678);
        send(1'b1, 32'h9ABC_DEF0);
        check_val("pre_rst_vout_w", 32'(bus_w.valid_out), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_val("mid_rst_vout_w", 32'(bus_w.valid_out), 32'd0);
        check_val("mid_rst_dout_w", bus_w.data_out, 32'd0);
        check_val("mid_rst_rin_w", 32'(bus_w.ready_in), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        got_n.delete();
        got_w.delete();
        repeat (4) tick();
        check_val("post_rst_stale", 32'(got_w.size()), 32'd0);

        // Default context after reset: K=0, encrypt
        send(1'b0, 32'h00);
        send(1'b0, 32'h00);
        send(1'b1, 32'h0000_0000);
        drain();
        check_seq("k0_0", 0, 32'h00);
        check_seq("k0_1", 1, 32'h08);
        check_val("k0_wide", (got_w.size() > 0) ? got_w[0] : 32'hFFFF_FFFF, 32'h1810_0800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
